// File: rtl/evo_bsp_pkg.sv
// Shared types and default constants for the SPI pass-through arbiter.
package evo_bsp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StGap
  } arb_state_e;

  localparam int unsigned DefGapCyc  = 2;
  localparam int unsigned DefHoldMax = 0;
  localparam int unsigned GapW       = 4;
  localparam int unsigned HoldW      = 16;

endpackage

// File: rtl/evo_spi_arb_if.sv
// Requester-side and pin-side signals of the shared SPI bus.
interface evo_spi_arb_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] req_sck_i;
  logic [NUM_REQ-1:0] req_mosi_i;
  logic [NUM_REQ-1:0] req_oe_i;
  logic               spi_miso_i;
  logic [NUM_REQ-1:0] grant_o;
  logic               spi_sck_o;
  logic               spi_mosi_o;
  logic               spi_oe_o;
  logic [NUM_REQ-1:0] req_miso_o;
  logic               busy_o;
  logic               timeout_o;

  // Requesters and the pin side.
  modport master (
    output req_i, req_sck_i, req_mosi_i, req_oe_i, spi_miso_i,
    input  grant_o, spi_sck_o, spi_mosi_o, spi_oe_o, req_miso_o, busy_o, timeout_o
  );

  // The arbiter.
  modport slave (
    input  req_i, req_sck_i, req_mosi_i, req_oe_i, spi_miso_i,
    output grant_o, spi_sck_o, spi_mosi_o, spi_oe_o, req_miso_o, busy_o, timeout_o
  );

endinterface

// File: rtl/evo_rr_pick.sv
// Combinational round-robin pick: first eligible index at or after last_owner+1.
module evo_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IdxW-1:0]    last_owner_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  logic [IdxW-1:0] idx;

  // Scan from the requester after the last owner, wrapping once around.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(last_owner_i) + i) % NUM_REQ);
      if (!valid_o && eligible_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/evo_spi_arb.sv
// Arbiter granting one requester at a time onto the pass-through SPI pins.
module evo_spi_arb
  import evo_bsp_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned GAP_CYC  = DefGapCyc,
  parameter int unsigned HOLD_MAX = DefHoldMax
) (
  input logic         clk,
  input logic         reset,
  evo_spi_arb_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [IdxW-1:0]    last_owner_q, last_owner_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [IdxW-1:0]    owner_idx;
  logic               owner_req;

  evo_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible_i   (bus.req_i & ~mask_q),
    .last_owner_i (last_owner_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

  // Decode the one-hot grant into an owner index.
  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = IdxW'(i);
      end
    end
  end

  assign owner_req = |(grant_q & bus.req_i);

  // Next-state logic for ownership, hold timeout and inter-owner gap.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    timeout_d    = 1'b0;
    // A revoked requester becomes eligible again once its request is seen low.
    mask_d       = mask_q & bus.req_i;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick;
          hold_d  = HoldW'(1);
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (!owner_req) begin
          grant_d      = '0;
          last_owner_d = owner_idx;
          hold_d       = '0;
          gap_d        = '0;
          state_d      = StGap;
        end else if (HOLD_MAX != 0 && hold_q == HoldW'(HOLD_MAX)) begin
          grant_d      = '0;
          last_owner_d = owner_idx;
          hold_d       = '0;
          gap_d        = '0;
          timeout_d    = 1'b1;
          mask_d       = mask_d | grant_q;
          state_d      = StGap;
        end else if (HOLD_MAX != 0) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StGap: begin
        // GAP always lasts at least one cycle, so GAP_CYC=0 behaves like a single cycle.
        if (32'(gap_q) + 32'd1 >= GAP_CYC) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      mask_q       <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      hold_q       <= '0;
      gap_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mask_q       <= mask_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      timeout_q    <= timeout_d;
    end
  end

  // Pin mux straight from the registered one-hot grant; zero when nobody owns the bus.
  assign bus.grant_o    = grant_q;
  assign bus.spi_sck_o  = |(grant_q & bus.req_sck_i);
  assign bus.spi_mosi_o = |(grant_q & bus.req_mosi_i);
  assign bus.spi_oe_o   = |(grant_q & bus.req_oe_i);
  assign bus.req_miso_o = grant_q & {NUM_REQ{bus.spi_miso_i}};
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.timeout_o  = timeout_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));

endmodule

// File: tb/tb_evo_spi_arb.sv
// Directed bench for evo_spi_arb: default, hold-limited and zero-gap instances.
module tb_evo_spi_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  evo_spi_arb_if #(.NUM_REQ(4)) a_if ();
  evo_spi_arb_if #(.NUM_REQ(4)) b_if ();
  evo_spi_arb_if #(.NUM_REQ(4)) c_if ();

  evo_spi_arb #(.NUM_REQ(4), .GAP_CYC(2), .HOLD_MAX(0)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  evo_spi_arb #(.NUM_REQ(4), .GAP_CYC(2), .HOLD_MAX(8)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  evo_spi_arb #(.NUM_REQ(4), .GAP_CYC(0), .HOLD_MAX(0)) u_c (
    .clk   (clk),
    .reset (reset),
    .bus   (c_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(a_if.grant_o), 0);
    chk("rst_busy", 32'(a_if.busy_o), 0);
    chk("rst_timeout", 32'(b_if.timeout_o), 0);
    chk("rst_oe", 32'(a_if.spi_oe_o), 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    a_if.req_i = '0; a_if.req_sck_i = '0; a_if.req_mosi_i = '0; a_if.req_oe_i = '0;
    a_if.spi_miso_i = 1'b0;
    b_if.req_i = '0; b_if.req_sck_i = '0; b_if.req_mosi_i = '0; b_if.req_oe_i = '0;
    b_if.spi_miso_i = 1'b0;
    c_if.req_i = '0; c_if.req_sck_i = '0; c_if.req_mosi_i = '0; c_if.req_oe_i = '0;
    c_if.spi_miso_i = 1'b0;

    // First grant after reset, then handover across a 2-cycle gap.
    do_reset();
    a_if.req_i = 4'b0110;
    tick();
    chk("first_grant", 32'(a_if.grant_o), 32'h2);
    tick();
    chk("hold_no_preempt", 32'(a_if.grant_o), 32'h2);
    a_if.req_i = 4'b0100;
    tick();
    chk("release_grant", 32'(a_if.grant_o), 0);
    chk("release_busy", 32'(a_if.busy_o), 1);
    tick();
    chk("gap2_grant", 32'(a_if.grant_o), 0);
    tick();
    chk("idle_grant", 32'(a_if.grant_o), 0);
    chk("idle_busy", 32'(a_if.busy_o), 0);
    tick();
    chk("second_grant", 32'(a_if.grant_o), 32'h4);
    a_if.req_i = '0;

    // All four requesting, each releasing after 3 owned cycles.
    do_reset();
    a_if.req_oe_i = 4'b1111;
    a_if.req_i    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      while (a_if.grant_o == 4'b0000 && n < 20) begin
        chk("rr_gap_oe", 32'(a_if.spi_oe_o), 0);
        tick();
        n++;
      end
      chk("rr_gap_len", 32'(n), (k == 0) ? 1 : 3);
      chk("rr_owner", 32'(a_if.grant_o), 32'(1) << (k % 4));
      tick();
      chk("rr_hold", 32'(a_if.grant_o), 32'(1) << (k % 4));
      tick();
      chk("rr_hold", 32'(a_if.grant_o), 32'(1) << (k % 4));
      a_if.req_i = 4'b1111 & ~(4'(1) << (k % 4));
      tick();
      chk("rr_release", 32'(a_if.grant_o), 0);
      a_if.req_i = 4'b1111;
    end
    a_if.req_i    = '0;
    a_if.req_oe_i = '0;

    // Mux: owner 3 drives the pins, others are ignored.
    do_reset();
    a_if.req_i      = 4'b1000;
    a_if.req_sck_i  = 4'b1000;
    a_if.req_mosi_i = 4'b1000;
    a_if.req_oe_i   = 4'b1000;
    a_if.spi_miso_i = 1'b1;
    tick();
    chk("mux_grant", 32'(a_if.grant_o), 32'h8);
    chk("mux_sck", 32'(a_if.spi_sck_o), 1);
    chk("mux_mosi", 32'(a_if.spi_mosi_o), 1);
    chk("mux_oe", 32'(a_if.spi_oe_o), 1);
    chk("mux_miso", 32'(a_if.req_miso_o), 32'h8);
    a_if.req_i      = 4'b1111;
    a_if.req_sck_i  = 4'b0111;
    a_if.req_mosi_i = 4'b0111;
    #1;
    chk("mux_other_sck", 32'(a_if.spi_sck_o), 0);
    chk("mux_other_mosi", 32'(a_if.spi_mosi_o), 0);
    a_if.spi_miso_i = 1'b0;
    #1;
    chk("mux_miso_low", 32'(a_if.req_miso_o), 0);
    tick();
    chk("mux_keep_owner", 32'(a_if.grant_o), 32'h8);

    // Asynchronous reset mid-ownership.
    reset = 1'b1;
    #1;
    chk("arst_grant", 32'(a_if.grant_o), 0);
    chk("arst_oe", 32'(a_if.spi_oe_o), 0);
    chk("arst_busy", 32'(a_if.busy_o), 0);
    #2;
    reset = 1'b0;
    a_if.req_i = 4'b1001;
    tick();
    chk("arst_regrant", 32'(a_if.grant_o), 32'h1);
    a_if.req_i = '0; a_if.req_sck_i = '0; a_if.req_mosi_i = '0; a_if.req_oe_i = '0;

    // Hold limit of 8 cycles and the post-timeout mask.
    do_reset();
    b_if.req_i = 4'b0100;
    tick();
    chk("hold_grant", 32'(b_if.grant_o), 32'h4);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("hold_run", 32'({b_if.timeout_o, b_if.grant_o}), 32'h04);
    end
    tick();
    chk("tmo_grant", 32'(b_if.grant_o), 0);
    chk("tmo_pulse", 32'(b_if.timeout_o), 1);
    tick();
    chk("tmo_pulse_end", 32'(b_if.timeout_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tmo_masked", 32'(b_if.grant_o), 0);
    end
    chk("tmo_idle", 32'(b_if.busy_o), 0);
    b_if.req_i = 4'b0000;
    tick();
    b_if.req_i = 4'b0100;
    tick();
    chk("tmo_unmasked", 32'(b_if.grant_o), 32'h4);
    b_if.req_i = '0;

    // Zero gap: sole requester is re-granted 2 cycles after release.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      c_if.req_i = 4'b0001;
      tick();
      if (k == 0) chk("g0_grant", 32'(c_if.grant_o), 32'h1);
      c_if.req_i = 4'b0000;
      tick();
      chk("g0_release", 32'({c_if.busy_o, c_if.grant_o}), 32'h10);
      c_if.req_i = 4'b0001;
      tick();
      chk("g0_idle", 32'({c_if.busy_o, c_if.grant_o}), 32'h00);
      tick();
      chk("g0_regrant", 32'(c_if.grant_o), 32'h1);
    end
    c_if.req_i = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evo_spi_arb.md
EVO_SPI_ARB -- requirements
Module: evo_spi_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the pass-through SPI bus (MISO/MOSI/SCK); requester 0 is the SAMD pass-through path.
REQ-002 Parameter GAP_CYC, default 2: idle cycles inserted between owners (0..15).
REQ-003 Parameter HOLD_MAX, default 0: maximum ownership in cycles (16-bit); 0 = unlimited.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_i  in  NUM_REQ  level request per requester, held high while the bus is wanted.
REQ-007 req_sck_i, req_mosi_i, req_oe_i  in  NUM_REQ each  per-requester SPI drive values and output enable.
REQ-008 spi_miso_i  in  1  bus MISO from pin.
REQ-009 grant_o  out  NUM_REQ  one-hot registered grant; all-zero when no owner.
REQ-010 spi_sck_o, spi_mosi_o, spi_oe_o  out  1 each  muxed drive to the pins.
REQ-011 req_miso_o  out  NUM_REQ  MISO returned to the owner only.
REQ-012 busy_o  out  1  high whenever state is not IDLE.
REQ-013 timeout_o  out  1  one-cycle pulse on forced revoke.

Function
REQ-014 The FSM SHALL have states IDLE, OWN, GAP.
REQ-015 IDLE: if any eligible req_i is high, the arbiter SHALL select the first eligible requester at or after (last_owner+1) mod NUM_REQ, assert its grant_o bit on the next edge, and enter OWN. Latency is req_i high to grant_o high in 1 cycle.
REQ-016 OWN: the grant SHALL hold while req_i[owner] is high; other requests SHALL NOT pre-empt it.
REQ-017 OWN: if req_i[owner] is low, grant_o SHALL clear on the next edge, last_owner SHALL update, and the FSM SHALL enter GAP.
REQ-018 OWN, HOLD_MAX≠0: the hold counter SHALL count from 1 on the grant cycle. When it equals HOLD_MAX with the request still high, the arbiter SHALL clear grant_o, pulse timeout_o for 1 cycle, and enter GAP.
REQ-019 After a timeout, the revoked requester SHALL stay ineligible until its req_i has been observed low for at least one cycle.
REQ-020 GAP: the arbiter SHALL stay exactly GAP_CYC cycles, then enter IDLE. With GAP_CYC=0 it SHALL enter IDLE on the next edge.
REQ-021 The output mux SHALL be combinational from the registered grant: spi_*_o = req_*_i[owner].
REQ-022 With no owner (IDLE/GAP), spi_sck_o, spi_mosi_o and spi_oe_o SHALL all be 0.
REQ-023 req_miso_o[owner] SHALL equal spi_miso_i; all other bits SHALL be 0.
REQ-024 A requester that drops and re-raises req_i during GAP SHALL compete normally in IDLE; a sole requester is re-granted after the gap.
REQ-025 grant_o SHALL never have more than one bit set (assertion).

Reset
REQ-026 Asserting reset SHALL immediately (asynchronously) force:
- state IDLE
- grant_o=0, timeout_o=0, busy_o=0
- hold counter 0, gap counter 0
- timeout masks cleared
- last_owner=NUM_REQ-1, so requester 0 wins first
REQ-027 Reset mid-ownership SHALL drop the bus drive to idle in the same cycle, with no glitch to another owner.

Structure
REQ-028 The state enum typedef and the default GAP_CYC/HOLD_MAX constants SHALL live in evo_bsp_pkg.
REQ-029 The round-robin selection SHALL be a combinational sub-module evo_rr_pick with parameter NUM_REQ, inputs (eligible vector, last_owner) and outputs (one-hot pick, valid).

Verification
REQ-030 Reset, then req_i=4'b0110 at cycle 0 -> grant_o=4'b0010 at cycle 1; after req_i[1] drops, grant clears and, after 2 idle cycles, grant_o=4'b0100.
REQ-031 req_i=4'b1111 held, each owner releasing after 3 cycles -> grant order 0,1,2,3,0, with 2-cycle gaps and spi_oe_o=0 in every gap.
REQ-032 HOLD_MAX=8, req_i[2] held high -> grant_o[2] clears and timeout_o pulses when the count reaches 8; requester 2 is not re-granted until its req_i toggles low.
REQ-033 Owner 3 driving sck=1, mosi=1, oe=1 with spi_miso_i=1 -> spi outputs are 1 and req_miso_o=4'b1000; other requesters' toggling has no effect.
REQ-034 reset pulsed mid-OWN -> grant_o=0 and spi_oe_o=0 in the same cycle; after release, req_i=4'b1001 -> requester 0 granted.
REQ-035 GAP_CYC=0, single requester toggling req_i -> re-grant 2 cycles after release; one-hot assertion never fires.
